// File: rtl/sfr_cmd_pkg.sv
// Shared types for the SFR command master: FSM states, operation codes and
// the upper bound on the SFR read latency.
package sfr_cmd_pkg;

   localparam int MAX_READ_LATENCY = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_RD_WAIT,
      S_RESP
   } sfr_state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } sfr_op_e;

endpackage

// File: rtl/sfr_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for queued SFR commands.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sfr_cmd_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sfr_cmd_master.sv
// SFR bus initiator: queues client commands and replays them on the SFR bus
// in order, returning read data through a valid/ready response port.
module sfr_cmd_master
   import sfr_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int CMD_DEPTH    = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  we,
   output logic                  re,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic                  busy
);

   localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_READ_LATENCY);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY - 1);

   sfr_state_e            state, next_state, issue_state;
   sfr_op_e               head_op;
   logic [CMD_W-1:0]      head;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  fifo_full, fifo_empty;
   logic                  pop, capture;
   logic [CNT_W-1:0]      lat_cnt;

   sfr_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmd_valid),
      .push_data ({cmd_write, cmd_addr, cmd_wdata}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_op     = sfr_op_e'(head[CMD_W-1]);
   assign head_addr   = head[DATA_WIDTH +: ADDR_WIDTH];
   assign head_data   = head[DATA_WIDTH-1:0];
   assign issue_state = (head_op == OP_WRITE) ? S_WRITE : S_READ;
   assign cmd_ready   = !fifo_full;
   assign busy        = !fifo_empty || (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE, S_WRITE: next_state = fifo_empty ? S_IDLE : issue_state;
         S_READ:          next_state = S_RD_WAIT;
         S_RD_WAIT:       if (lat_cnt == LAT_LAST) next_state = S_RESP;
         S_RESP:          if (rsp_ready) next_state = fifo_empty ? S_IDLE : issue_state;
         default:         next_state = S_IDLE;
      endcase
   end

   // A new command is only popped when the bus is free and no response is held.
   always_comb begin
      pop     = 1'b0;
      capture = 1'b0;
      case (state)
         S_IDLE, S_WRITE: pop     = !fifo_empty;
         S_RD_WAIT:       capture = (lat_cnt == LAT_LAST);
         S_RESP:          pop     = rsp_ready && !fifo_empty;
         default:         ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we         <= 1'b0;
         re         <= 1'b0;
         address    <= '0;
         write_data <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         lat_cnt    <= '0;
      end else begin
         we        <= pop && (head_op == OP_WRITE);
         re        <= pop && (head_op == OP_READ);
         rsp_valid <= (next_state == S_RESP);
         lat_cnt   <= (state == S_RD_WAIT) ? lat_cnt + 1'b1 : '0;
         if (pop) address <= head_addr;
         if (pop && head_op == OP_WRITE) write_data <= head_data;
         if (capture) rsp_data <= read_data;
      end
   end

endmodule

// File: tb/tb_sfr_cmd_master.sv
// Bench for sfr_cmd_master: two instances (read latency 1 and 3), each with an
// SFR register block model, checked every cycle against a transaction-level model.
module tb_sfr_cmd_master;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid [2];
   logic          cmd_ready [2];
   logic          cmd_write [2];
   logic [AW-1:0] cmd_addr  [2];
   logic [DW-1:0] cmd_wdata [2];
   logic          rsp_valid [2];
   logic          rsp_ready [2];
   logic [DW-1:0] rsp_data  [2];
   logic [AW-1:0] address   [2];
   logic [DW-1:0] write_data[2];
   logic          we        [2];
   logic          re        [2];
   logic [DW-1:0] read_data [2];
   logic          busy      [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   sfr_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .READ_LATENCY(1)) u_dut0 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
      .address(address[0]), .write_data(write_data[0]), .we(we[0]), .re(re[0]),
      .read_data(read_data[0]), .busy(busy[0]));

   sfr_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .READ_LATENCY(3)) u_dut1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
      .address(address[1]), .write_data(write_data[1]), .we(we[1]), .re(re[1]),
      .read_data(read_data[1]), .busy(busy[1]));

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SFR register block per instance: data appears READ_LATENCY cycles after re,
   // for exactly one cycle; otherwise the bus carries a moving junk pattern.
   logic [DW-1:0] sfr_mem [2][256];
   logic [DW-1:0] rd_pipe [2][4];
   logic [3:0]    rd_vld  [2];

   always @(posedge clk or posedge reset) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            rd_vld[d] <= '0;
            for (int i = 0; i < 256; i++) sfr_mem[d][i] <= '0;
         end else begin
            if (we[d]) sfr_mem[d][address[d][7:0]] <= write_data[d];
            rd_vld[d]     <= {rd_vld[d][2:0], re[d]};
            rd_pipe[d][0] <= sfr_mem[d][address[d][7:0]];
            for (int s = 1; s < 4; s++) rd_pipe[d][s] <= rd_pipe[d][s-1];
         end
      end
   end

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         read_data[d] = 32'hBAD0_0000 ^ 32'(cyc);
         if (rd_vld[d][lat(d)-1]) read_data[d] = rd_pipe[d][lat(d)-1];
      end
   end

   // Transaction-level model: accepted commands wait in a queue, the head issues
   // two cycles after acceptance at the earliest and never while a read is open.
   typedef struct {int d; bit w; logic [AW-1:0] a; logic [DW-1:0] v; int acc;} cmd_t;
   cmd_t          mq[$];
   bit            rd_pend   [2];
   int            rsp_start [2];
   logic [DW-1:0] rsp_val   [2];
   logic [AW-1:0] addr_hold [2];
   logic [DW-1:0] mdl_mem   [2][256];

   function automatic int head_idx(input int d);
      for (int i = 0; i < mq.size(); i++) if (mq[i].d == d) return i;
      return -1;
   endfunction

   function automatic int count_of(input int d);
      int n = 0;
      for (int i = 0; i < mq.size(); i++) if (mq[i].d == d) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         automatic int  h;
         automatic int  n;
         automatic bit  strobe, exp_we, exp_re, exp_ready, exp_rv;
         if (reset) begin
            check($sformatf("d%0d_rst_we", d), we[d], 0);
            check($sformatf("d%0d_rst_re", d), re[d], 0);
            check($sformatf("d%0d_rst_rsp_valid", d), rsp_valid[d], 0);
            check($sformatf("d%0d_rst_busy", d), busy[d], 0);
            check($sformatf("d%0d_rst_cmd_ready", d), cmd_ready[d], 1);
            check($sformatf("d%0d_rst_address", d), address[d], 0);
            check($sformatf("d%0d_rst_write_data", d), write_data[d], 0);
            check($sformatf("d%0d_rst_rsp_data", d), rsp_data[d], 0);
            for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].d == d) mq.delete(i);
            rd_pend[d]   = 0;
            addr_hold[d] = '0;
            for (int i = 0; i < 256; i++) mdl_mem[d][i] = '0;
         end else begin
            h = head_idx(d);
            n = count_of(d);
            strobe = (h >= 0) && !rd_pend[d];
            if (strobe) strobe = (mq[h].acc + 2 <= cyc);
            exp_we = 0;
            exp_re = 0;
            if (strobe) begin
               exp_we = mq[h].w;
               exp_re = !mq[h].w;
               addr_hold[d] = mq[h].a;
            end
            exp_ready = (n - int'(strobe)) < DEPTH;
            exp_rv    = rd_pend[d] && (cyc >= rsp_start[d]);
            check($sformatf("d%0d_we", d), we[d], exp_we);
            check($sformatf("d%0d_re", d), re[d], exp_re);
            check($sformatf("d%0d_we_re_excl", d), we[d] & re[d], 0);
            check($sformatf("d%0d_cmd_ready", d), cmd_ready[d], exp_ready);
            check($sformatf("d%0d_busy", d), busy[d], (n > 0) || rd_pend[d]);
            check($sformatf("d%0d_address", d), address[d], addr_hold[d]);
            check($sformatf("d%0d_rsp_valid", d), rsp_valid[d], exp_rv);
            if (exp_we) check($sformatf("d%0d_write_data", d), write_data[d], mq[h].v);
            if (exp_rv) check($sformatf("d%0d_rsp_data", d), rsp_data[d], rsp_val[d]);
            if (exp_rv && rsp_ready[d]) rd_pend[d] = 0;
            if (strobe) begin
               if (mq[h].w) mdl_mem[d][mq[h].a[7:0]] = mq[h].v;
               else begin
                  rd_pend[d]   = 1;
                  rsp_start[d] = cyc + lat(d) + 1;
                  rsp_val[d]   = mdl_mem[d][mq[h].a[7:0]];
               end
               mq.delete(h);
            end
            if (cmd_valid[d] && exp_ready)
               mq.push_back('{d, cmd_write[d], cmd_addr[d], cmd_wdata[d], cyc});
         end
      end
   end

   // Event log used by the directed tests for hand-computed expectations.
   typedef struct {int d; bit w; int c; logic [AW-1:0] a; logic [DW-1:0] v;} ev_t;
   ev_t slog[$];
   ev_t rlog[$];
   bit  prev_rv [2] = '{0, 0};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!reset) begin
            if (we[d]) slog.push_back('{d, 1'b1, cyc, address[d], write_data[d]});
            if (re[d]) slog.push_back('{d, 1'b0, cyc, address[d], '0});
            if (rsp_valid[d] && !prev_rv[d]) rlog.push_back('{d, 1'b0, cyc, '0, rsp_data[d]});
         end
         prev_rv[d] = !reset && rsp_valid[d];
      end
   end

   function automatic int n_ev(input int d, input bit rsp);
      ev_t src[$];
      int  n = 0;
      src = rsp ? rlog : slog;
      foreach (src[i]) if (src[i].d == d) n++;
      return n;
   endfunction

   function automatic ev_t nth_ev(input int d, input int k, input bit rsp);
      ev_t src[$];
      ev_t none = '{d, 1'b0, -1, '0, '0};
      int  seen = 0;
      src = rsp ? rlog : slog;
      foreach (src[i]) if (src[i].d == d) begin
         if (seen == k) return src[i];
         seen++;
      end
      return none;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int d, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] v,
                       output int acc);
      bit done = 0;
      acc = -1;
      cmd_valid[d] = 1'b1;
      cmd_write[d] = w;
      cmd_addr[d]  = a;
      cmd_wdata[d] = v;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready[d]) begin
            acc  = cyc;
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      cmd_valid[d] = 1'b0;
      if (!done) check("push_timeout", 0, 1);
   endtask

   // Offers writes 0x30+idx while idx < 5; optionally checks the held response.
   task automatic offer(input int d, input int ncyc, input bit hold_chk, inout int idx);
      bit taken;
      repeat (ncyc) begin
         cmd_valid[d] = (idx < 5);
         cmd_write[d] = 1'b1;
         cmd_addr[d]  = 16'h0030 + 16'(idx);
         cmd_wdata[d] = 32'hC0DE_0000 + 32'(idx);
         @(negedge clk);
         if (hold_chk) begin
            check("t4_rsp_valid_hold", rsp_valid[d], 1);
            check("t4_rsp_data_hold", rsp_data[d], 32'h1234_5678);
         end
         taken = cmd_valid[d] && cmd_ready[d];
         @(posedge clk);
         #1;
         if (taken) idx++;
      end
      cmd_valid[d] = 1'b0;
   endtask

   task automatic rand_drive(input int d);
      repeat (1000) begin
         cmd_valid[d] = 1'($urandom_range(0, 1));
         cmd_write[d] = 1'($urandom_range(0, 1));
         cmd_addr[d]  = 16'($urandom_range(0, 15));
         cmd_wdata[d] = $urandom;
         rsp_ready[d] = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      cmd_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc, idx;
      ev_t  e, r;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 1'b0;
         cmd_write[d] = 1'b0;
         cmd_addr[d]  = '0;
         cmd_wdata[d] = '0;
         rsp_ready[d] = 1'b1;
      end
      wait_cycles(3);
      check("reset_cmd_ready", cmd_ready[0], 1);
      check("reset_busy", busy[1], 0);
      reset = 1'b0;
      wait_cycles(2);

      // Single write: strobe two cycles after acceptance, then idle.
      slog.delete();
      push(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, acc);
      wait_cycles(6);
      e = nth_ev(0, 0, 0);
      check("t1_we_count", n_ev(0, 0), 1);
      check("t1_latency", e.c - acc, 2);
      check("t1_address", e.a, 16'h0010);
      check("t1_wdata", e.v, 32'hDEAD_BEEF);
      check("t1_busy_idle", busy[0], 0);

      // Four back-to-back writes: four consecutive strobes, in order.
      slog.delete();
      for (int i = 0; i < 4; i++) push(0, 1'b1, 16'(i), 32'hA000_0000 + 32'(i), acc);
      wait_cycles(8);
      check("t2_we_count", n_ev(0, 0), 4);
      for (int i = 0; i < 4; i++) begin
         e = nth_ev(0, i, 0);
         check($sformatf("t2_addr%0d", i), e.a, 16'(i));
         check($sformatf("t2_gap%0d", i), e.c - nth_ev(0, 0, 0).c, i);
      end

      // Write then read back at both latencies: rsp_valid at R+2 and R+4.
      for (int d = 0; d < 2; d++) begin
         slog.delete();
         rlog.delete();
         push(d, 1'b1, 16'h0020, 32'h1234_5678, acc);
         push(d, 1'b0, 16'h0020, 32'h0, acc);
         wait_cycles(12);
         e = nth_ev(d, 1, 0);
         r = nth_ev(d, 0, 1);
         check($sformatf("t3_d%0d_is_read", d), e.w, 0);
         check($sformatf("t3_d%0d_rsp_lat", d), r.c - e.c, (d == 0) ? 2 : 4);
         check($sformatf("t3_d%0d_rsp_data", d), r.v, 32'h1234_5678);
      end

      // Response held for 10 cycles while five writes are offered.
      rsp_ready[0] = 1'b0;
      push(0, 1'b0, 16'h0020, 32'h0, acc);
      wait_cycles(5);
      check("t4_rsp_valid", rsp_valid[0], 1);
      slog.delete();
      idx = 0;
      offer(0, 10, 1'b1, idx);
      check("t4_accepts", idx, 4);
      check("t4_full", cmd_ready[0], 0);
      check("t4_no_strobe", n_ev(0, 0), 0);
      rsp_ready[0] = 1'b1;
      offer(0, 10, 1'b0, idx);
      check("t4_all_accepted", idx, 5);
      wait_cycles(10);
      check("t4_strobes", n_ev(0, 0), 5);
      for (int i = 0; i < 5; i++) check($sformatf("t4_order%0d", i), nth_ev(0, i, 0).a, 16'h0030 + 16'(i));

      // Reset during RD_WAIT with three writes queued behind the read.
      slog.delete();
      push(1, 1'b0, 16'h0020, 32'h0, acc);
      for (int i = 0; i < 3; i++) push(1, 1'b1, 16'h0040 + 16'(i), 32'h5500_0000 + 32'(i), acc);
      e = nth_ev(1, 0, 0);
      check("t5_in_rd_wait", (e.c >= 0) && (cyc > e.c) && (cyc <= e.c + 3), 1);
      check("t5_busy_before", busy[1], 1);
      reset = 1'b1;
      #1;
      check("t5_re_drop", re[1], 0);
      check("t5_we_drop", we[1], 0);
      check("t5_rsp_valid_drop", rsp_valid[1], 0);
      check("t5_cmd_ready", cmd_ready[1], 1);
      wait_cycles(2);
      reset = 1'b0;
      slog.delete();
      wait_cycles(10);
      check("t5_no_activity", n_ev(1, 0), 0);
      check("t5_cmd_ready_after", cmd_ready[1], 1);
      check("t5_busy_after", busy[1], 0);

      // Random traffic on both instances.
      slog.delete();
      fork
         rand_drive(0);
         rand_drive(1);
      join
      wait_cycles(30);
      check("t6_reads_seen", n_ev(0, 1) > 10 && n_ev(1, 1) > 10, 1);
      check("t6_drain_busy0", busy[0], 0);
      check("t6_drain_busy1", busy[1], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
